// File: rtl/rsc_viterbi_dec.sv
// Hard-decision Viterbi decoder, 4-state (1,5/7) RSC, one terminated BLK+2 step block at a time.
// Result 36 edges after acceptance; no input buffering, result held while out_ready_i is low.
module rsc_viterbi_dec #(
    parameter int BLK = 16,
    parameter int PMW = 7
) (
    input  logic           clk_p_i,
    input  logic           reset_p_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [BLK+1:0] sys_i,
    input  logic [BLK+1:0] par_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [BLK-1:0] data_o,
    output logic [5:0]     metric_o
);

    localparam int NSTEP = BLK + 2;
    localparam int KW    = $clog2(NSTEP);
    localparam logic [KW-1:0]  K_LAST = KW'(NSTEP - 1);
    localparam logic [KW-1:0]  K_DATA = KW'(BLK);
    localparam logic [PMW-1:0] PM_INF = PMW'(64);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACS   = 2'd1;
    localparam logic [1:0] S_TRACE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     r_state;
    logic [KW-1:0]  r_k;
    logic [BLK+1:0] r_sys;
    logic [BLK+1:0] r_par;
    logic [PMW-1:0] r_pm [4];
    logic [3:0]     r_sv [NSTEP];
    logic [1:0]     r_tst;
    logic [BLK-1:0] r_data;
    logic [5:0]     r_metric;
    logic           r_out_vld;

    logic [KW-1:0]  w_bit_idx;
    logic           w_sys_b;
    logic           w_par_b;
    logic [PMW-1:0] w_pm_nxt [4];
    logic [3:0]     w_sel;
    logic [5:0]     w_metric;
    logic           w_tr_s2;
    logic           w_tr_d;

    function automatic logic [PMW-1:0] f_cand(
        input logic [PMW-1:0] pm,
        input logic           a,
        input logic           b,
        input logic           s2,
        input logic           sb,
        input logic           pb
    );
        logic d;
        logic p;
        d = a ^ b ^ s2;
        p = a ^ s2;
        return pm + PMW'(d ^ sb) + PMW'(p ^ pb);
    endfunction

    // Step k consumes bit position NSTEP-1-k (step 0 sits in the MSB).
    assign w_bit_idx = K_LAST - r_k;
    assign w_sys_b   = r_sys[w_bit_idx];
    assign w_par_b   = r_par[w_bit_idx];

    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        logic [PMW-1:0] w_c0;
        logic [PMW-1:0] w_c1;
        assign w_c0        = f_cand(r_pm[{NS[0], 1'b0}], NS[1], NS[0], 1'b0, w_sys_b, w_par_b);
        assign w_c1        = f_cand(r_pm[{NS[0], 1'b1}], NS[1], NS[0], 1'b1, w_sys_b, w_par_b);
        assign w_sel[g]    = (w_c1 < w_c0);
        assign w_pm_nxt[g] = w_sel[g] ? w_c1 : w_c0;
    end

    assign w_metric = (w_pm_nxt[0] > PMW'(63)) ? 6'd63 : w_pm_nxt[0][5:0];

    // Traceback: survivor bit is s2 of the predecessor {b,s2} of state {a,b}.
    assign w_tr_s2 = r_sv[r_k][r_tst];
    assign w_tr_d  = r_tst[1] ^ r_tst[0] ^ w_tr_s2;

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_sys     <= '0;
            r_par     <= '0;
            r_tst     <= '0;
            r_data    <= '0;
            r_metric  <= '0;
            r_out_vld <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_pm[i] <= '0;
            end
            for (int i = 0; i < NSTEP; i++) begin
                r_sv[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_sys   <= sys_i;
                        r_par   <= par_i;
                        r_pm[0] <= '0;
                        r_pm[1] <= PM_INF;
                        r_pm[2] <= PM_INF;
                        r_pm[3] <= PM_INF;
                        r_k     <= '0;
                        r_state <= S_ACS;
                    end
                end
                S_ACS: begin
                    for (int i = 0; i < 4; i++) begin
                        r_pm[i] <= w_pm_nxt[i];
                    end
                    r_sv[r_k] <= w_sel;
                    if (r_k == K_LAST) begin
                        r_metric <= w_metric;
                        r_tst    <= 2'b00;
                        r_state  <= S_TRACE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_TRACE: begin
                    r_tst <= {r_tst[0], w_tr_s2};
                    // Data bits arrive k=BLK-1 first; shifting in at the MSB lands step k at BLK-1-k.
                    if (r_k < K_DATA) begin
                        r_data <= {w_tr_d, r_data[BLK-1:1]};
                    end
                    if (r_k == '0) begin
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                default: begin
                    if (out_ready_i) begin
                        r_out_vld <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = r_out_vld;
    assign data_o      = r_data;
    assign metric_o    = r_metric;

endmodule

// File: tb/tb_rsc_viterbi_dec.sv
// Bench for rsc_viterbi_dec: directed vectors plus randomized blocks from a reference encoder.
module tb_rsc_viterbi_dec;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] sys = '0;
    logic [17:0] par = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] data;
    logic [5:0]  metric;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rsc_viterbi_dec dut (
        .clk_p_i     (clk),
        .reset_p_i   (reset_p),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sys_i       (sys),
        .par_i       (par),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data),
        .metric_o    (metric)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference RSC encoder: a=d^s1^s2, p=a^s2, next {a,s1}; tail input forces a=0.
    function automatic void encode(input logic [15:0] d, output logic [17:0] s, output logic [17:0] p);
        logic s1, s2, u, a;
        s1 = 1'b0;
        s2 = 1'b0;
        s  = '0;
        p  = '0;
        for (int t = 0; t < 18; t++) begin
            u = (t < 16) ? d[15 - t] : (s1 ^ s2);
            a = u ^ s1 ^ s2;
            s[17 - t] = u;
            p[17 - t] = a ^ s2;
            s2 = s1;
            s1 = a;
        end
    endfunction

    task automatic send(input logic [17:0] s, input logic [17:0] p);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        sys = s;
        par = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sys = 18'($urandom);
        par = 18'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    logic [17:0] es, ep;
    logic [15:0] ed, hold_d;
    logic [5:0]  hold_m;
    int lat, nflip, pos;
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_p = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_metric", metric, 0);

        // All-zero block with exact latency.
        send(18'h00000, 18'h00000);
        wait_out(lat);
        chk("zero_latency", lat, 36);
        chk("zero_data", data, 16'h0000);
        chk("zero_metric", metric, 0);

        send(18'h20003, 18'h3B6D9);
        wait_out(lat);
        chk("d8000_data", data, 16'h8000);
        chk("d8000_metric", metric, 0);

        send(18'h20003, 18'h3B6D9 ^ 18'h00010);
        wait_out(lat);
        chk("parflip_data", data, 16'h8000);
        chk("parflip_metric", metric, 1);

        send(18'h20003 ^ 18'h01000, 18'h3B6D9);
        wait_out(lat);
        chk("sysflip_data", data, 16'h8000);
        chk("sysflip_metric", metric, 1);

        // Random blocks with zero or one channel error.
        for (int i = 0; i < 1000; i++) begin
            ed = 16'($urandom);
            encode(ed, es, ep);
            nflip = $urandom_range(0, 1);
            if (nflip == 1) begin
                pos = $urandom_range(0, 35);
                if (pos < 18) es[pos] = ~es[pos];
                else          ep[pos - 18] = ~ep[pos - 18];
            end
            send(es, ep);
            wait_out(lat);
            chk("rand_data", data, ed);
            chk("rand_metric", metric, nflip);
        end

        // Backpressure in DONE.
        @(posedge clk); #1;
        out_ready = 1'b0;
        ed = 16'($urandom);
        encode(ed, es, ep);
        send(es, ep);
        wait_out(lat);
        chk("bp_data", data, ed);
        chk("bp_metric", metric, 0);
        hold_d = data;
        hold_m = metric;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", out_valid, 1);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_data_stable", data, hold_d);
            chk("bp_metric_stable", metric, hold_m);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_data", data, hold_d);

        // Reset while the ACS step k=7 is pending.
        ed = 16'($urandom);
        encode(ed, es, ep);
        send(es, ep);
        repeat (7) @(posedge clk);
        #1;
        reset_p = 1'b1;
        @(posedge clk); #1;
        reset_p = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_metric", metric, 0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_output", seen, 0);

        ed = 16'($urandom);
        encode(ed, es, ep);
        es[9] = ~es[9];
        send(es, ep);
        wait_out(lat);
        chk("postrst_latency", lat, 36);
        chk("postrst_data", data, ed);
        chk("postrst_metric", metric, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
